// File: rtl/cache_pkg.sv
// ============================================================================
// Module      : cache_pkg
// Description : Shared types and default widths for the cache backing responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_pkg;
    localparam int C_ADDR_WIDTH = 16;
    localparam int C_DATA_WIDTH = 8;
    localparam int C_CNT_WIDTH  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;
endpackage

`default_nettype wire

// File: rtl/resp_mem_array.sv
// ============================================================================
// Module      : resp_mem_array
// Description : Single-port synchronous word array with a registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module resp_mem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // Contents deliberately survive reset; only the read register tracks accesses.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        if (re) begin
            r_rdata <= r_mem[addr];
        end
    end

    assign rdata = r_rdata;
endmodule

`default_nettype wire

// File: rtl/cache_backing_responder.sv
// ============================================================================
// Module      : cache_backing_responder
// Description : Fixed-latency single-word memory responder for cache misses.
//               Build macro WRITE_ACK_EN makes writes return a response beat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_backing_responder
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = C_ADDR_WIDTH,
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int MEM_DEPTH  = 256,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);
    localparam int AW = $clog2(MEM_DEPTH);

    resp_state_t            r_state;
    resp_state_t            w_next;
    logic [C_CNT_WIDTH-1:0] r_cnt;
    logic                   r_we;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic                   r_err;
    logic                   r_rdata_ok;
    logic                   w_oor;
    logic                   w_access;
    logic                   w_mem_we;
    logic                   w_mem_re;
    logic [DATA_WIDTH-1:0]  w_mem_rdata;

    // Any set bit above the array index means the word is not held here.
    generate
        if (AW < ADDR_WIDTH) begin : g_range_check
            assign w_oor = |r_addr[ADDR_WIDTH-1:AW];
        end else begin : g_full_range
            assign w_oor = 1'b0;
        end
    endgenerate

    assign w_access = (r_state == WAIT) && (r_cnt == '0);
    assign w_mem_we = w_access && r_we && !w_oor && !rst;
    assign w_mem_re = w_access && !r_we && !w_oor && !rst;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (req_valid) w_next = WAIT;
            WAIT: begin
                if (w_access) begin
`ifdef WRITE_ACK_EN
                    w_next = RESP;
`else
                    w_next = r_we ? IDLE : RESP;
`endif
                end
            end
            RESP: if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_err      <= 1'b0;
            r_rdata_ok <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_cnt   <= C_CNT_WIDTH'(LATENCY - 1);
                    end
                end
                WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        // Error flag only matters when a beat will actually be presented.
                        r_err      <= (w_next == RESP) && w_oor;
                        r_rdata_ok <= !r_we && !w_oor;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_err      <= 1'b0;
                        r_rdata_ok <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    resp_mem_array #(
        .DEPTH (MEM_DEPTH),
        .AW    (AW),
        .DW    (DATA_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_mem_we),
        .re    (w_mem_re),
        .addr  (r_addr[AW-1:0]),
        .wdata (r_wdata),
        .rdata (w_mem_rdata)
    );

    assign req_ready = (r_state == IDLE) && !rst;
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rdata_ok ? w_mem_rdata : '0;
    assign rsp_err   = r_err;
endmodule

`default_nettype wire

// File: tb/tb_cache_backing_responder.sv
// ============================================================================
// Module      : tb_cache_backing_responder
// Description : Scoreboard bench for cache_backing_responder (LATENCY=2, depth 256).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_backing_responder;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;

    typedef struct {
        logic [7:0] d;
        logic       e;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    logic       prev_valid = 1'b0;
    logic [7:0] hold_d;
    logic       hold_e;

    cache_backing_responder #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (8),
        .MEM_DEPTH  (256),
        .LATENCY    (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: first cycle of each beat is matched against the scoreboard, later cycles must hold.
    always @(negedge clk) begin
        if (rst !== 1'b0) begin
            prev_valid <= 1'b0;
        end else if (rsp_valid === 1'b1) begin
            if (!prev_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp: got beat data 0x%0h err %0d, expected none", rsp_rdata, rsp_err);
                end else begin
                    exp_t x;
                    x = q.pop_front();
                    chk("rsp_rdata", int'(rsp_rdata), int'(x.d));
                    chk("rsp_err", int'(rsp_err), int'(x.e));
                    chk("rsp_latency_cycle", cyc, x.cyc);
                end
                hold_d <= rsp_rdata;
                hold_e <= rsp_err;
            end else begin
                chk("rsp_rdata_hold", int'(rsp_rdata), int'(hold_d));
                chk("rsp_err_hold", int'(rsp_err), int'(hold_e));
            end
            prev_valid <= 1'b1;
        end else begin
            prev_valid <= 1'b0;
        end
    end

    task automatic issue(input logic we, input logic [15:0] a, input logic [7:0] d, output int acc);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL req_ready_timeout: got %b, expected 1 within 50 cycles", req_ready);
            acc       = -1;
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc       = cyc;
        req_valid = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, input logic [7:0] d, input logic e);
        int acc;
        exp_t x;
        issue(1'b0, a, d, acc);
        x.d = d; x.e = e; x.cyc = acc + LAT;
        q.push_back(x);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input logic e, output int acc);
        issue(1'b1, a, d, acc);
`ifdef WRITE_ACK_EN
        begin
            exp_t x;
            x.d = 8'h00; x.e = e; x.cyc = acc + LAT;
            q.push_back(x);
        end
`else
        if (e) begin end
`endif
    endtask

    initial begin
        int acc;
        int n;
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 16'h0000;
        req_wdata = 8'hFF;
        rsp_ready = 1'b1;

        // Reset held for three cycles with a request pending
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_req_ready", int'(req_ready), 0);
            chk("rst_rsp_valid", int'(rsp_valid), 0);
            chk("rst_rsp_rdata", int'(rsp_rdata), 0);
            chk("rst_rsp_err", int'(rsp_err), 0);
        end
        rst       = 1'b0;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_req_ready", int'(req_ready), 1);

        // Write then read back
        do_write(16'h0000, 8'hAA, 1'b0, acc);
        do_write(16'h0008, 8'h11, 1'b0, acc);
        do_read(16'h0000, 8'hAA, 1'b0);
        do_read(16'h0008, 8'h11, 1'b0);

        // Backpressure on a read
        do_write(16'h0004, 8'h55, 1'b0, acc);
        do_read(16'h0004, 8'h55, 1'b0);
        rsp_ready = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", int'(rsp_valid), 1);
            chk("bp_rsp_rdata", int'(rsp_rdata), 8'h55);
            chk("bp_req_ready", int'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_rsp_valid", int'(rsp_valid), 0);
        chk("bp_release_req_ready", int'(req_ready), 1);

        // Out-of-range accesses
        do_read(16'h0100, 8'h00, 1'b1);
        do_write(16'h0100, 8'h77, 1'b1, acc);
        do_read(16'h0000, 8'hAA, 1'b0);
        do_read(16'hFFFF, 8'h00, 1'b1);

        // Reset during WAIT of a write drops it
        issue(1'b1, 16'h0008, 8'h33, acc);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("aborted_write_rsp_valid", int'(rsp_valid), 0);
        end
        do_read(16'h0008, 8'h11, 1'b0);

        // Write to 0x0010 and read it back
        do_write(16'h0010, 8'h5A, 1'b0, acc);
`ifndef WRITE_ACK_EN
        for (int k = 1; k <= LAT + 1; k++) begin
            @(posedge clk);
            #1;
            chk("noack_rsp_valid", int'(rsp_valid), 0);
            if (k == 1) chk("noack_req_ready_wait", int'(req_ready), 0);
            if (k == LAT + 1) chk("noack_req_ready_back", int'(req_ready), 1);
        end
`endif
        do_read(16'h0010, 8'h5A, 1'b0);
        do_read(16'h0004, 8'h55, 1'b0);

        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
